// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM state type,
// byte width, default requester count and a constant-width helper.
package uart_tx_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo NUM_REQ (rotate, priority-encode, rotate back).
module tx_rr_picker
    import uart_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ-1:0]   rot;
    logic [2*NUM_REQ-1:0] dbl;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    always_comb begin
        // Doubling the vector lets a plain right shift act as a rotate by ptr.
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        valid = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rot[i] && !valid) begin
                valid = 1'b1;
                off   = IDX_W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/tx_arbiter_module.sv
// Round-robin arbiter/sequencer sharing one UART byte transmitter among NUM_REQ
// requesters. Optional BUSY watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module tx_arbiter_module
    import uart_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] Req_Data,
    output logic [NUM_REQ-1:0]             Ack,
    output logic                           TX_En_Sig,
    output logic [UART_BYTE_W-1:0]         TX_Data,
    input  logic                           TX_Done_Sig,
    output logic                           Busy,
    output logic [IDX_W-1:0]               Grant_Idx,
    output logic                           Timeout_Err
);

    if (IDX_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("tx_arbiter_module: inconsistent NUM_REQ/IDX_W/TIMEOUT_CYCLES");
    end

    arb_state_t             state;
    logic [IDX_W-1:0]       ptr;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [UART_BYTE_W-1:0] sel_byte;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [IDX_W-1:0]       next_ptr;

    tx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (Req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        sel_byte               = Req_Data[{Grant_Idx, 3'b000} +: UART_BYTE_W];
        grant_onehot           = '0;
        grant_onehot[Grant_Idx] = 1'b1;
        next_ptr               = (Grant_Idx == IDX_W'(NUM_REQ - 1)) ? '0 : Grant_Idx + 1'b1;
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign Timeout_Err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            Grant_Idx <= '0;
            TX_Data   <= '0;
            TX_En_Sig <= 1'b0;
            Ack       <= '0;
            Busy      <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            Timeout_Err <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            Ack <= '0;
`ifdef TX_ARB_TIMEOUT_EN
            Timeout_Err <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        Grant_Idx <= pick_idx;
                        Busy      <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    TX_Data   <= sel_byte;
                    TX_En_Sig <= 1'b1;
`ifdef TX_ARB_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                    state     <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Done takes priority over the watchdog on the limit cycle.
                    if (TX_Done_Sig) begin
                        TX_En_Sig <= 1'b0;
                        Ack       <= grant_onehot;
                        ptr       <= next_ptr;
                        state     <= ST_GAP;
                    end
`ifdef TX_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LIMIT) begin
                        TX_En_Sig   <= 1'b0;
                        Timeout_Err <= 1'b1;
                        ptr         <= next_ptr;
                        state       <= ST_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter_module.sv
// Self-checking bench for tx_arbiter_module: directed scenarios plus randomized
// requesters/datapath, checked every cycle against a frame-level reference model.
module tb_tx_arbiter_module;

    localparam int N  = 4;
    localparam int TO = 50;
`ifdef TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   Req = '0;
    logic [8*N-1:0] Req_Data = '0;
    logic           TX_Done_Sig = 1'b0;
    logic [N-1:0]   Ack;
    logic           TX_En_Sig;
    logic [7:0]     TX_Data;
    logic           Busy;
    logic [1:0]     Grant_Idx;
    logic           Timeout_Err;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    tx_arbiter_module #(
        .NUM_REQ        (N),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Req         (Req),
        .Req_Data    (Req_Data),
        .Ack         (Ack),
        .TX_En_Sig   (TX_En_Sig),
        .TX_Data     (TX_Data),
        .TX_Done_Sig (TX_Done_Sig),
        .Busy        (Busy),
        .Grant_Idx   (Grant_Idx),
        .Timeout_Err (Timeout_Err)
    );

    // Frame-level model: a frame is described by the edge it was granted on
    // (m_g) and the edge it ended on (m_d, -1 while open); outputs follow from
    // the position of the current edge relative to those.
    int         edge_n = 0;
    bit         m_active = 0;
    int         m_w = 0, m_g = 0, m_d = -1, m_ptr = 0, m_last = 0;
    bit         m_to = 0;
    logic [7:0] m_data = '0;

    // Stimulus state
    int         mode = 0;          // 0 directed, 1 release/reassert on Ack, 2 random
    int         done_after = 0;    // 0: datapath never completes
    int         en_cycles = 0;
    bit         spurious = 0;
    bit         last_busy = 0, busy_rose = 0;
    logic [N-1:0] restore = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_update();
        edge_n++;
        if (!RST_N) begin
            m_active = 0; m_ptr = 0; m_data = '0; m_last = 0; m_d = -1; m_to = 0;
        end else if (!m_active) begin
            if (Req != '0) begin
                m_w = rr_pick(Req, m_ptr); m_last = m_w;
                m_active = 1; m_g = edge_n; m_d = -1; m_to = 0;
            end
        end else if (m_d < 0) begin
            if (edge_n == m_g + 1) begin
                m_data = Req_Data[8*m_w +: 8];
            end else if (TX_Done_Sig) begin
                m_d = edge_n; m_ptr = (m_w + 1) % N;
            end else if (TO_EN && (edge_n - (m_g + 2)) == TO - 1) begin
                m_d = edge_n; m_to = 1; m_ptr = (m_w + 1) % N;
            end
        end else begin
            m_active = 0;
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_ack;
        bit e_en, e_terr;
        e_ack = '0;
        if (m_active && m_d == edge_n && !m_to) e_ack[m_w] = 1'b1;
        e_en   = m_active && m_d < 0 && edge_n >= m_g + 1;
        e_terr = m_active && m_d == edge_n && m_to;
        check("busy",      32'(Busy),        32'(m_active));
        check("tx_en",     32'(TX_En_Sig),   32'(e_en));
        check("ack",       32'(Ack),         32'(e_ack));
        check("tx_data",   32'(TX_Data),     32'(m_data));
        check("grant_idx", 32'(Grant_Idx),   32'(m_last));
        check("timeout",   32'(Timeout_Err), 32'(e_terr));
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        compare();
        busy_rose = Busy && !last_busy;
        last_busy = Busy;
        if (mode == 2 && busy_rose) done_after = $urandom_range(1, 20);
        if (TX_En_Sig) en_cycles++; else en_cycles = 0;
        TX_Done_Sig = (TX_En_Sig && done_after != 0 && en_cycles == done_after) ||
                      (!TX_En_Sig && spurious && $urandom_range(0, 7) == 0);
        if (mode == 1) begin
            Req = Req | restore;
            restore = '0;
            if (Ack != '0) begin
                Req = Req & ~Ack;
                restore = Ack;
            end
        end else if (mode == 2) begin
            RST_N = ($urandom_range(0, 499) != 0);
            for (int k = 0; k < N; k++) begin
                if (Ack[k]) begin
                    Req[k] = 1'($urandom_range(0, 1));
                    Req_Data[8*k +: 8] = 8'($urandom);
                end else if (!Req[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        Req[k] = 1'b1;
                        Req_Data[8*k +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 99) == 0) begin
                    Req[k] = 1'b0;
                end
            end
        end
    endtask

    // what: 0 = Busy rising, 1 = any Ack, 2 = Timeout_Err
    task automatic wait_for(input int what, input int limit, input string name, output int cycles);
        for (int n = 1; n <= limit; n++) begin
            step();
            cycles = n;
            if ((what == 0 && busy_rose) || (what == 1 && Ack != '0) || (what == 2 && Timeout_Err)) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: event not seen within %0d cycles (required: seen)", name, limit);
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        repeat (n) step();
        RST_N = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int cyc;

    initial begin
        // Reset, then an idle bus
        do_reset(3);
        repeat (20) step();
        check("idle_busy",  32'(Busy), 32'd0);
        check("idle_en",    32'(TX_En_Sig), 32'd0);
        check("idle_ack",   32'(Ack), 32'd0);
        check("idle_grant", 32'(Grant_Idx), 32'd0);

        // Single request on index 2
        done_after = 100;
        Req_Data = 32'h11A5_2233;
        Req = 4'b0100;
        step();
        check("t2_grant", 32'(Grant_Idx), 32'd2);
        check("t2_en_early", 32'(TX_En_Sig), 32'd0);
        step();
        check("t2_en", 32'(TX_En_Sig), 32'd1);
        check("t2_data", 32'(TX_Data), 32'hA5);
        wait_for(1, 200, "t2_ack", cyc);
        check("t2_ack", 32'(Ack), 32'b0100);
        check("t2_en_drop", 32'(TX_En_Sig), 32'd0);
        Req = '0;
        repeat (3) step();

        // All four held, released for one cycle on each Ack
        do_reset(1);
        mode = 1;
        done_after = 4;
        Req_Data = 32'h4433_2211;
        Req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_for(0, 40, "t3_grant_wait", cyc);
            check("t3_order", 32'(Grant_Idx), 32'(exp_order[g]));
        end
        mode = 0;
        Req = '0;
        repeat (12) step();

        // Request withdrawn mid-frame
        do_reset(1);
        done_after = 30;
        Req_Data = 32'h0000_5C00;
        Req = 4'b0010;
        wait_for(0, 10, "t4_grant_wait", cyc);
        repeat (3) step();
        Req = '0;
        Req_Data = '0;
        wait_for(1, 60, "t4_ack_wait", cyc);
        check("t4_ack", 32'(Ack), 32'b0010);
        check("t4_data", 32'(TX_Data), 32'h5C);
        repeat (3) step();

        // Reset in the middle of a frame restarts the search at index 0
        done_after = 10;
        Req = 4'b0100;
        wait_for(1, 40, "t5_ack_wait", cyc);
        Req = '0;
        repeat (2) step();
        Req = 4'b1001;
        wait_for(0, 10, "t5_grant_wait", cyc);
        check("t5_grant_ptr", 32'(Grant_Idx), 32'd3);
        repeat (3) step();
        do_reset(1);
        check("t5_rst_en", 32'(TX_En_Sig), 32'd0);
        check("t5_rst_ack", 32'(Ack), 32'd0);
        check("t5_rst_grant", 32'(Grant_Idx), 32'd0);
        wait_for(0, 10, "t5_regrant_wait", cyc);
        check("t5_regrant", 32'(Grant_Idx), 32'd0);
        wait_for(1, 40, "t5_ack2_wait", cyc);
        Req = '0;
        repeat (3) step();

`ifdef TX_ARB_TIMEOUT_EN
        // Watchdog: grant edge, one GRANT edge, then 50 BUSY edges
        done_after = 0;
        Req = 4'b0010;
        wait_for(0, 10, "t6_grant_wait", cyc);
        wait_for(2, 200, "t6_timeout_wait", cyc);
        check("t6_cycles", 32'(cyc), 32'd51);
        check("t6_noack", 32'(Ack), 32'd0);
        check("t6_en", 32'(TX_En_Sig), 32'd0);
        done_after = 5;
        Req = 4'b1111;
        wait_for(0, 10, "t6_next_wait", cyc);
        check("t6_next", 32'(Grant_Idx), 32'd2);
        Req = '0;
        repeat (10) step();
`endif

        // Randomized requesters, datapath delays, stray done pulses, resets
        do_reset(1);
        mode = 2;
        spurious = 1;
        repeat (3000) step();
        mode = 0;
        RST_N = 1'b1;
        Req = '0;
        repeat (30) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_arbiter_module.md
Name: tx_arbiter_module

Overview:
Round-robin arbiter and sequencer that shares one UART byte transmitter (the tx_control_module datapath) among NUM_REQ requesters. It latches the winning requester's byte and holds the transmitter enable for the whole frame. It then drops the enable on the done pulse and acknowledges the requester. It sits between the application sources (command echo, status reporter, debug dump) and the TX datapath. It shares CLK and RST_N with that datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
IDX_W, 2, width of the grant index; must equal ceil(log2(NUM_REQ)).
TIMEOUT_CYCLES, 1000000, BUSY-state watchdog limit in CLK cycles (used only with the optional feature).

Ports:
CLK  in  1  system clock; all logic on its rising edge.
RST_N  in  1  synchronous active-low reset, sampled on the CLK rising edge.
Req  in  NUM_REQ  per-requester transmit request; level, held until Ack.
Req_Data  in  8*NUM_REQ  byte per requester; requester k uses bits [8k+7:8k].
Ack  out  NUM_REQ  one-cycle pulse on the granted bit when its byte has completed.
TX_En_Sig  out  1  enable to the TX datapath; high for the entire frame.
TX_Data  out  8  byte to the TX datapath; stable while TX_En_Sig=1.
TX_Done_Sig  in  1  one-cycle done pulse from the TX datapath.
Busy  out  1  high in the GRANT, BUSY and GAP states.
Grant_Idx  out  IDX_W  index of the current or last granted requester.
Timeout_Err  out  1  one-cycle pulse when a frame is aborted by the watchdog.

Behaviour:
- Reset (synchronous, RST_N=0 at a rising edge):
  - state=IDLE.
  - Ack=0, TX_En_Sig=0, TX_Data=8'h00, Busy=0, Grant_Idx=0, Timeout_Err=0.
  - Round-robin pointer ptr=0.
  - Reset mid-frame aborts the frame with no Ack; the datapath is reset by the same RST_N.
- States: IDLE, GRANT, BUSY, GAP. All outputs are registered.
- IDLE:
  - If Req != 0, pick the first set bit searching ptr, ptr+1, ... and wrapping modulo NUM_REQ.
  - Register the winner into Grant_Idx and go to GRANT.
  - If Req == 0, stay in IDLE.
- GRANT (1 cycle):
  - TX_Data <= Req_Data slice of Grant_Idx; TX_En_Sig <= 1; go to BUSY.
  - Latency: TX_En_Sig rises 2 cycles after Req is first sampled high in IDLE.
- BUSY:
  - Hold TX_En_Sig=1 and TX_Data unchanged.
  - Ignore Req changes; a withdrawn Req does not abort the frame.
  - On TX_Done_Sig=1: TX_En_Sig <= 0, Ack[Grant_Idx] <= 1, ptr <= (Grant_Idx+1) mod NUM_REQ, go to GAP.
- GAP (1 cycle):
  - Ack returns to 0; go to IDLE.
  - This lets the datapath finish its post-done cleanup cycle before the enable can reassert.
  - A requester updates Req/Req_Data on the edge after seeing Ack; IDLE samples the new value.
- TX_Done_Sig outside BUSY is ignored.
- Throughput: each byte costs the datapath frame time plus 3 CLK cycles (GRANT, GAP, IDLE).
- Fairness: a requester holding Req continuously is granted at most once per NUM_REQ grants while others are requesting.
- Single requester: back-to-back frames go to the same index.
- ptr wrap: after granting index NUM_REQ-1, ptr=0.

Optional Feature:
Macro TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES)) clears on GRANT and increments in BUSY.
  - If it reaches TIMEOUT_CYCLES-1 without TX_Done_Sig, then: TX_En_Sig <= 0, Timeout_Err pulses 1 cycle, no Ack, ptr advances as for completion, go to GAP.
  - If TX_Done_Sig arrives on the same cycle as the limit, done wins: Ack is issued and there is no error.
- Undefined: no counter is built, Timeout_Err is tied 0, and BUSY waits indefinitely.

Decomposition:
- Package uart_tx_pkg:
  - state encoding constants ST_IDLE, ST_GRANT, ST_BUSY, ST_GAP (2-bit).
  - default NUM_REQ.
  - a clog2 helper function.
  - UART_BYTE_W=8.
- One natural sub-module, tx_rr_picker:
  - combinational rotate-priority-rotate search.
  - Inputs: Req, ptr. Outputs: valid, winner index.

Test Plan:
1. Reset hold, then Req=4'b0000 for 20 cycles -> all outputs 0, Busy=0, no TX_En_Sig.
2. Req=4'b0100, Req_Data byte2=8'hA5 -> Grant_Idx=2; TX_En_Sig high 2 cycles later with TX_Data=8'hA5; model done after 100 cycles -> Ack=4'b0100 pulse for 1 cycle; TX_En_Sig low on that same cycle.
3. Req=4'b1111 held, Ack bit cleared then reasserted each grant -> grant order 0,1,2,3,0; TX_En_Sig low for ≥1 cycle between frames.
4. Req[1] dropped mid-BUSY -> frame completes; Ack[1] still pulses; TX_Data is unchanged throughout.
5. RST_N=0 for 1 cycle mid-BUSY -> next cycle TX_En_Sig=0, Ack=0, Grant_Idx=0; the following grant search starts at index 0.
6. (TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50) done never arrives -> Timeout_Err pulses at BUSY cycle 50; no Ack; next request is granted at ptr+1.
